// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the single SRAM driver: latches the winning request,
// holds it on drv_* until the driver completes, then pulses the winner's ready.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 16,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  drv_valid,
  output logic                  drv_we,
  output logic [ADDR_WIDTH-1:0] drv_addr,
  output logic [DATA_WIDTH-1:0] drv_wdata,
  input  logic                  drv_ready,
  input  logic [DATA_WIDTH-1:0] drv_rdata,
  output logic [1:0]            grant
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t                state, state_nxt;
  logic                  last_grant;
  logic [BW-1:0]         burst_cnt;
  logic                  any_req;
  logic                  win1;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  assign any_req = req0_valid | req1_valid;

  // Winner if a grant is made this cycle; only consulted in IDLE.
  always_comb begin
    win1 = req1_valid;
    if (req0_valid && req1_valid) begin
      if (FIXED_PRIO) win1 = (burst_cnt == BURST_MAX);
      else            win1 = !last_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= 1'b1;
      burst_cnt  <= '0;
      drv_we     <= 1'b0;
      drv_addr   <= '0;
      drv_wdata  <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant      <= win1 ? 2'b10 : 2'b01;
            last_grant <= win1;
            drv_we     <= win1 ? req1_we    : req0_we;
            drv_addr   <= win1 ? req1_addr  : req0_addr;
            drv_wdata  <= win1 ? req1_wdata : req0_wdata;
            // Counts port-0 wins only while port 1 is actually waiting.
            if (win1 || !req1_valid)      burst_cnt <= '0;
            else if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          if (drv_ready && !drv_we) begin
            if (grant[1]) rdata1_q <= drv_rdata;
            else          rdata0_q <= drv_rdata;
          end
        end
        S_DONE:  grant <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req)   state_nxt = S_ISSUE;
      S_ISSUE: if (drv_ready) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    drv_valid  = (state == S_ISSUE);
    req0_ready = (state == S_DONE) && grant[0];
    req1_ready = (state == S_DONE) && grant[1];
    req0_rdata = rdata0_q;
    req1_rdata = rdata1_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a round-robin instance (index 0) and a fixed-priority
// instance (index 1, MAX_BURST=8) driven by directed and random transactions.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv   [2][2];
  logic        rwe  [2][2];
  logic [18:0] ra   [2][2];
  logic [15:0] rwd  [2][2];
  logic        rrdy [2][2];
  logic [15:0] rrd  [2][2];
  logic        dv   [2];
  logic        dwe  [2];
  logic [18:0] da   [2];
  logic [15:0] dwd  [2];
  logic        drdy [2];
  logic [15:0] drd  [2];
  logic [1:0]  gnt  [2];

  int total = 0;
  int bad   = 0;

  // Reference state: last winner, consecutive port-0 wins with port 1 waiting, last read data
  int          m_last [2];
  int          m_run  [2];
  logic [15:0] m_rd   [2][2];

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_WIDTH(19), .DATA_WIDTH(16), .FIXED_PRIO(1'b0), .MAX_BURST(8)) u_rr (
    .clk(clk), .reset(rst),
    .req0_valid(rv[0][0]), .req0_we(rwe[0][0]), .req0_addr(ra[0][0]), .req0_wdata(rwd[0][0]),
    .req0_ready(rrdy[0][0]), .req0_rdata(rrd[0][0]),
    .req1_valid(rv[0][1]), .req1_we(rwe[0][1]), .req1_addr(ra[0][1]), .req1_wdata(rwd[0][1]),
    .req1_ready(rrdy[0][1]), .req1_rdata(rrd[0][1]),
    .drv_valid(dv[0]), .drv_we(dwe[0]), .drv_addr(da[0]), .drv_wdata(dwd[0]),
    .drv_ready(drdy[0]), .drv_rdata(drd[0]), .grant(gnt[0])
  );

  sram_arbiter #(.ADDR_WIDTH(19), .DATA_WIDTH(16), .FIXED_PRIO(1'b1), .MAX_BURST(8)) u_fp (
    .clk(clk), .reset(rst),
    .req0_valid(rv[1][0]), .req0_we(rwe[1][0]), .req0_addr(ra[1][0]), .req0_wdata(rwd[1][0]),
    .req0_ready(rrdy[1][0]), .req0_rdata(rrd[1][0]),
    .req1_valid(rv[1][1]), .req1_we(rwe[1][1]), .req1_addr(ra[1][1]), .req1_wdata(rwd[1][1]),
    .req1_ready(rrdy[1][1]), .req1_rdata(rrd[1][1]),
    .drv_valid(dv[1]), .drv_we(dwe[1]), .drv_addr(da[1]), .drv_wdata(dwd[1]),
    .drv_ready(drdy[1]), .drv_rdata(drd[1]), .grant(gnt[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_last[i] = 1;
      m_run[i]  = 0;
      m_rd[i][0] = '0;
      m_rd[i][1] = '0;
    end
  endtask

  task automatic new_req(input int i, input int p);
    rv[i][p]  = 1'b1;
    rwe[i][p] = 1'($urandom_range(0, 1));
    ra[i][p]  = 19'($urandom);
    rwd[i][p] = 16'($urandom);
  endtask

  // Called with the DUT in IDLE and requests set up; returns with the DUT back in IDLE.
  task automatic serve(input int i, input int lat, input logic [15:0] rdv, output int w);
    logic        v0, v1, ewe;
    logic [18:0] ea;
    logic [15:0] ewd;
    v0 = rv[i][0];
    v1 = rv[i][1];
    if (v0 && v1) begin
      if (i == 1) w = (m_run[i] >= 8) ? 1 : 0;
      else        w = (m_last[i] == 0) ? 1 : 0;
    end else begin
      w = v0 ? 0 : 1;
    end
    ewe = rwe[i][w];
    ea  = ra[i][w];
    ewd = rwd[i][w];
    tick();
    chk("issue_valid", dv[i], 1);
    chk("issue_grant", gnt[i], (w == 0) ? 1 : 2);
    chk("issue_we", dwe[i], ewe);
    chk("issue_addr", da[i], ea);
    chk("issue_wdata", dwd[i], ewd);
    for (int c = 0; c < lat; c++) begin
      tick();
      chk("hold_valid", dv[i], 1);
      chk("hold_addr", da[i], ea);
      chk("hold_wdata", dwd[i], ewd);
      chk("hold_ready0", rrdy[i][0], 0);
      chk("hold_ready1", rrdy[i][1], 0);
    end
    drdy[i] = 1'b1;
    drd[i]  = rdv;
    tick();
    drdy[i] = 1'b0;
    drd[i]  = 16'($urandom);
    if (!ewe) m_rd[i][w] = rdv;
    if (w == 0 && v1) m_run[i] = (m_run[i] < 8) ? m_run[i] + 1 : 8;
    else              m_run[i] = 0;
    m_last[i] = w;
    chk("done_ready_win", rrdy[i][w], 1);
    chk("done_ready_other", rrdy[i][1-w], 0);
    chk("done_drv_valid", dv[i], 0);
    chk("done_rdata_win", rrd[i][w], m_rd[i][w]);
    chk("done_rdata_other", rrd[i][1-w], m_rd[i][1-w]);
    tick();
    chk("idle_grant", gnt[i], 0);
    chk("idle_ready", rrdy[i][w], 0);
  endtask

  initial begin
    int w;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drdy[i] = 1'b0;
      drd[i]  = '0;
      for (int p = 0; p < 2; p++) begin
        rv[i][p] = 1'b0; rwe[i][p] = 1'b0; ra[i][p] = '0; rwd[i][p] = '0;
      end
    end
    reset_model();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_drv_valid", dv[i], 0);
      chk("rst_drv_we", dwe[i], 0);
      chk("rst_drv_addr", da[i], 0);
      chk("rst_drv_wdata", dwd[i], 0);
      chk("rst_grant", gnt[i], 0);
      chk("rst_ready0", rrdy[i][0], 0);
      chk("rst_ready1", rrdy[i][1], 0);
      chk("rst_rdata0", rrd[i][0], 0);
      chk("rst_rdata1", rrd[i][1], 0);
    end

    // Port 0 read, driver answers 0xBEEF after 2 cycles
    rv[0][0] = 1'b1; rwe[0][0] = 1'b0; ra[0][0] = 19'h00010; rwd[0][0] = 16'h0;
    serve(0, 2, 16'hBEEF, w);
    chk("t1_rdata", rrd[0][0], 16'hBEEF);
    rv[0][0] = 1'b0;

    // Port 1 write to the top address
    rv[0][1] = 1'b1; rwe[0][1] = 1'b1; ra[0][1] = 19'h7FFFF; rwd[0][1] = 16'h1234;
    serve(0, 1, 16'h5A5A, w);
    chk("t2_winner", w, 1);
    chk("t2_rdata1_unchanged", rrd[0][1], 0);
    rv[0][1] = 1'b0;

    // Round-robin alternation with both ports continuously requesting
    new_req(0, 0);
    new_req(0, 1);
    for (int k = 0; k < 6; k++) begin
      serve(0, $urandom_range(0, 2), 16'($urandom), w);
      chk("t3_rr_alt", w, k % 2);
      new_req(0, w);
    end
    rv[0][0] = 1'b0; rv[0][1] = 1'b0;

    // Fixed priority: eight port-0 grants, then one port-1 grant, twice
    new_req(1, 0);
    new_req(1, 1);
    for (int k = 0; k < 18; k++) begin
      serve(1, $urandom_range(0, 2), 16'($urandom), w);
      chk("t4_fp_burst", w, (k % 9 == 8) ? 1 : 0);
      new_req(1, w);
    end
    rv[1][0] = 1'b0; rv[1][1] = 1'b0;

    // Reset while a transaction is in ISSUE
    new_req(0, 0);
    rwe[0][0] = 1'b0;
    tick();
    chk("t5_pre_valid", dv[0], 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rv[0][0] = 1'b0;
    reset_model();
    chk("t5_drv_valid", dv[0], 0);
    chk("t5_grant", gnt[0], 0);
    chk("t5_ready0", rrdy[0][0], 0);
    chk("t5_rdata0", rrd[0][0], 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_quiet_ready0", rrdy[0][0], 0);
      chk("t5_quiet_valid", dv[0], 0);
    end
    new_req(0, 1);
    serve(0, 1, 16'($urandom), w);
    chk("t5_fresh_winner", w, 1);
    rv[0][1] = 1'b0;

    // Driver holds off 20 cycles with the other port pending
    new_req(0, 0);
    new_req(0, 1);
    serve(0, 20, 16'($urandom), w);
    chk("t6_winner", w, 0);
    rv[0][0] = 1'b0; rv[0][1] = 1'b0;

    // Random traffic on both instances
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 150; k++) begin
        if (!rv[i][0] && !rv[i][1]) begin
          for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            tick();
            chk("gap_grant", gnt[i], 0);
            chk("gap_valid", dv[i], 0);
          end
          case ($urandom_range(0, 2))
            0:       new_req(i, 0);
            1:       new_req(i, 1);
            default: begin new_req(i, 0); new_req(i, 1); end
          endcase
        end
        serve(i, $urandom_range(0, 3), 16'($urandom), w);
        if ($urandom_range(0, 3) != 0) new_req(i, w);
        else rv[i][w] = 1'b0;
        if (rv[i][1-w] && $urandom_range(0, 7) == 0) rv[i][1-w] = 1'b0;
      end
      rv[i][0] = 1'b0;
      rv[i][1] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
